// File: rtl/tflip_bank_sequencer.sv
// Command sequencer driving a bank of T flip-flop cells: count up/down, load
// and clear are realised purely as per-cell toggle enables.

module tflip_cell (
    input  logic Clk,
    input  logic clr,
    input  logic t,
    output logic q
);
    always_ff @(posedge Clk) begin
        if (clr)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end
endmodule

module tflip_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_LOAD, OP_CLEAR} op_t;

    state_t           state;
    op_t              op;
    logic [CW-1:0]    remaining;
    logic [WIDTH-1:0] data_r;
    logic             ready_r;
    logic             done_r;
    logic             wrap_r;
    logic             clear;
    logic             chain;

    assign clear     = ~reset;
    assign cmd_ready = ready_r;
    assign busy      = ~ready_r;
    assign done      = done_r;
    assign wrap      = wrap_r;

    // Up toggles bit i when all lower bits are 1; down when all lower bits are 0.
    always_comb begin
        t_en  = '0;
        chain = 1'b1;
        if (state == RUN) begin
            case (op)
                OP_UP: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        t_en[i] = chain;
                        chain   = chain & q[i];
                    end
                end
                OP_DOWN: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        t_en[i] = chain;
                        chain   = chain & ~q[i];
                    end
                end
                OP_LOAD:  t_en = q ^ data_r;
                OP_CLEAR: t_en = q;
                default:  t_en = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= OP_UP;
            remaining <= '0;
            data_r    <= '0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op        <= op_t'(cmd_op);
                        remaining <= cmd_count;
                        data_r    <= cmd_data;
                        wrap_r    <= 1'b0;
                        ready_r   <= 1'b0;
                        if (!cmd_op[1] && cmd_count == '0) begin
                            state  <= FINISH;
                            done_r <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op == OP_UP || op == OP_DOWN) begin
                        if ((op == OP_UP && &q) || (op == OP_DOWN && ~|q))
                            wrap_r <= 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state  <= FINISH;
                            done_r <= 1'b1;
                        end
                    end else begin
                        state  <= FINISH;
                        done_r <= 1'b1;
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tflip_cell u_cell (
            .Clk (Clk),
            .clr (clear),
            .t   (t_en[i]),
            .q   (q[i])
        );
    end
endmodule

// File: tb/tb_tflip_bank_sequencer.sv
// Bench for tflip_bank_sequencer: command table with scoreboarded completions
// plus hand sequences for reset, the up-count toggle pattern and mid-run abort.

module tb_tflip_bank_sequencer;
    localparam int WIDTH = 4;
    localparam int CW    = 8;

    logic             Clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = '0;
    logic [CW-1:0]    cmd_count = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_ready;
    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    tflip_bank_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .t_en      (t_en),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             wrap;
        int               lat;
        int               acc;
    } exp_t;

    typedef struct {
        logic [1:0]       op;
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] t_first;
        logic [WIDTH-1:0] exp_q;
        logic             exp_wrap;
        int               lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_q", 32'(q), 32'(e.q));
                chk("done_wrap", 32'(wrap), 32'(e.wrap));
                chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [CW-1:0] cnt,
                         input logic [WIDTH-1:0] d, input bit track,
                         input logic [WIDTH-1:0] eq, input logic ew, input int lat);
        int t;
        t = 0;
        @(negedge Clk);
        while (cmd_ready !== 1'b1 && t < 1000) begin
            @(negedge Clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = d;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        if (track) begin
            exp_t e;
            e.q    = eq;
            e.wrap = ew;
            e.lat  = lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 600) begin
            @(negedge Clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] up5_seq[5];
        int               start_cnt;

        up5_seq = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1};
        // Table starts from q=5, left behind by the hand-checked up-5 sequence.
        vecs[0]  = '{2'b10, 8'd0,   4'hA, 4'hF, 4'hA, 1'b0, 1};
        vecs[1]  = '{2'b11, 8'd0,   4'h0, 4'hA, 4'h0, 1'b0, 1};
        vecs[2]  = '{2'b10, 8'd0,   4'hA, 4'hA, 4'hA, 1'b0, 1};
        vecs[3]  = '{2'b00, 8'd7,   4'h0, 4'h1, 4'h1, 1'b1, 7};
        vecs[4]  = '{2'b00, 8'd1,   4'h0, 4'h3, 4'h2, 1'b0, 1};
        vecs[5]  = '{2'b11, 8'd0,   4'h0, 4'h2, 4'h0, 1'b0, 1};
        vecs[6]  = '{2'b01, 8'd3,   4'h0, 4'hF, 4'hD, 1'b1, 3};
        vecs[7]  = '{2'b00, 8'd0,   4'h0, 4'h0, 4'hD, 1'b0, 0};
        vecs[8]  = '{2'b00, 8'd255, 4'h0, 4'h3, 4'hC, 1'b1, 255};
        vecs[9]  = '{2'b01, 8'd16,  4'h0, 4'h7, 4'hC, 1'b1, 16};
        vecs[10] = '{2'b10, 8'd0,   4'h0, 4'hC, 4'h0, 1'b0, 1};

        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'h7;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_t_en", 32'(t_en), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge Clk);
        chk("post_rst_q", 32'(q), 32'h0);
        chk("post_rst_ready", 32'(cmd_ready), 32'h1);

        issue(2'b00, 8'd5, 4'h0, 1'b1, 4'h5, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("up5_t_en", 32'(t_en), 32'(up5_seq[i]));
            chk("up5_busy", 32'(busy), 32'h1);
        end
        @(negedge Clk);
        chk("up5_done", 32'(done), 32'h1);
        chk("up5_ready_at_done", 32'(cmd_ready), 32'h0);
        chk("up5_t_en_finish", 32'(t_en), 32'h0);
        @(negedge Clk);
        chk("up5_ready_after", 32'(cmd_ready), 32'h1);
        chk("up5_done_cleared", 32'(done), 32'h0);
        chk("up5_q_hold", 32'(q), 32'h5);
        wait_done();

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].count, vecs[i].data, 1'b1,
                  vecs[i].exp_q, vecs[i].exp_wrap, vecs[i].lat);
            @(negedge Clk);
            chk("vec_t_en_first", 32'(t_en), 32'(vecs[i].t_first));
            wait_done();
        end

        // Abort: down 10 from 0, ignored load while busy, reset after 3rd step.
        start_cnt = done_cnt;
        issue(2'b01, 8'd10, 4'h0, 1'b0, 4'h0, 1'b0, 0);
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'h5;
        chk("abort_ready_busy", 32'(cmd_ready), 32'h0);
        chk("abort_busy", 32'(busy), 32'h1);
        @(negedge Clk);
        cmd_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_q_3steps", 32'(q), 32'hD);
        reset = 1'b0;
        @(negedge Clk);
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        chk("abort_t_en", 32'(t_en), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        reset = 1'b1;
        repeat (15) @(negedge Clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - start_cnt), 32'h0);
        chk("abort_idle_q", 32'(q), 32'h0);
        chk("abort_idle_wrap", 32'(wrap), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tflip_bank_sequencer.md
Name: tflip_bank_sequencer

Overview:
Command-driven controller for a bank of WIDTH toggle cells. Each cell behaves as the team's T flip-flop: synchronous clear, and Q inverts on the Clk rising edge when its enable is high. The sequencer accepts one command at a time (count up, count down, load or clear) and computes the per-cell toggle enables every cycle. It reports completion with a one-cycle done pulse and a wrap flag, and sits between a host FSM and the toggle bank, which is instantiated inside the block.

Parameters:
WIDTH, 4, number of toggle cells (bits of q)
CW, 8, width of step-count field cmd_count

Ports:
Clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  00 count up, 01 count down, 10 load, 11 clear
cmd_count  input  CW  number of count steps (up/down only)
cmd_data  input  WIDTH  target value for load
t_en  output  WIDTH  toggle enables currently applied to the bank
q  output  WIDTH  toggle bank state
busy  output  1  command in progress (RUN or FINISH)
done  output  1  one-cycle completion pulse
wrap  output  1  sticky: a count step wrapped during the last command

Behaviour:
- Clock and reset: single clock Clk. reset is synchronous and active-low: sampled on the Clk rising edge, and the block resets when it is 0.
- Reset state: state=IDLE, q=0, remaining count=0, op register=00, wrap=0, done=0, busy=0, t_en=0, cmd_ready=1. Reset overrides any command in flight, including mid-RUN; no done pulse is produced for an aborted command.
- Handshake: a command is accepted on an edge where cmd_valid=1 and cmd_ready=1. cmd_op, cmd_count and cmd_data are captured at that edge, and wrap is cleared. cmd_valid while busy is ignored; nothing is queued.
- States:
  - IDLE: t_en=0. On accept, go to RUN if (op is up/down and cmd_count≠0) or op is load/clear. Go to FINISH if op is up/down and cmd_count=0.
  - RUN: t_en is driven combinationally from the current q and the captured op (see below).
    - up/down: one step per cycle. The remaining count decrements each cycle; leave RUN after the edge that applies the last step.
    - load/clear: exactly one RUN cycle.
  - FINISH: t_en=0, done=1, busy=1. Unconditional return to IDLE next edge.
- Toggle enable rules (RUN only):
  - up: t_en[0]=1; t_en[i]=AND of q[i-1:0].
  - down: t_en[0]=1; t_en[i]=AND of ~q[i-1:0].
  - load: t_en=q XOR cmd_data (captured value).
  - clear: t_en=q.
- Bank update: on each edge, q <= q XOR t_en.
- Wrap: wrap sets on any up step taken with q=all-ones or any down step taken with q=0. It stays set until the next accept or reset. Load and clear never set it.
- Timing: with accept at edge k and N≥1 count steps, toggles are applied at edges k+1..k+N. done=1 and q holds its final value during the cycle after edge k+N. cmd_ready=1 again after edge k+N+1.
  - Load/clear behave as N=1.
  - Count with N=0: done during the cycle after edge k; q unchanged.
- Arithmetic: modulo 2^WIDTH. Remaining count is CW bits, so a single command covers at most 2^CW−1 steps.
- busy equals NOT cmd_ready at all times.

Test Plan:
1. Reset: hold reset=0 for 2 edges with cmd_valid=1 -> q=0, t_en=0, done=0, wrap=0, cmd_ready=1; no command accepted.
2. Count up: from q=0, op=00, count=5 accepted at edge k -> t_en=1,3,1,7,1 during the 5 RUN cycles; q=5 with done=1 exactly one cycle after edge k+5; wrap=0; cmd_ready=1 after edge k+6.
3. Load: from q=5, op=10, data=4'hA -> t_en=4'hF for one cycle, then q=4'hA with done; then op=11 -> t_en=4'hA, q=0, done.
4. Wrap on up count: load 4'hA, then up count 7 -> q=4'h1, wrap=1 at done. Next accept (up count 1) clears wrap -> q=2, wrap=0.
5. Down count and zero count: from q=0, down count 3 -> q=4'hD, wrap=1. Then up count 0 -> done on the cycle after accept, q=4'hD, t_en stays 0.
6. Abort and busy rejection: down count 10 from q=0. Pulse cmd_valid with op=10 during RUN -> ignored, cmd_ready=0. Drive reset=0 at the edge after the 3rd step -> q=0, IDLE, cmd_ready=1, no done pulse ever for that command.
